// File: rtl/uc_arbiter_if.sv
// Bundle between the unit-clause arbiter, its literal queues and the propagation engines.
interface uc_arbiter_if #(
  parameter int NUM_Q = 4,
  parameter int LIT_W = 9
);
  logic [NUM_Q-1:0]            q_empty;
  logic [NUM_Q-1:0][LIT_W-1:0] q_data;
  logic [NUM_Q-1:0]            pop;
  logic                        bcast_valid;
  logic [LIT_W-1:0]            bcast_lit;
  logic                        bcast_ready;
  logic                        flush;
  logic                        conflict;

  // Broadcast handshake: a transfer happens on a rising edge where
  // bcast_valid && bcast_ready. Once raised, bcast_valid stays high and
  // bcast_lit stays stable until that transfer. bcast_ready is ignored
  // while bcast_valid is low.
  modport master (
    input  q_empty, q_data, bcast_ready, flush,
    output pop, bcast_valid, bcast_lit, conflict
  );

  modport slave (
    output q_empty, q_data, bcast_ready, flush,
    input  pop, bcast_valid, bcast_lit, conflict
  );
endinterface

// File: rtl/uc_arbiter.sv
// Round-robin unit-clause arbiter: pops one literal at a time and broadcasts it.
// Define UCA_HIST_FILTER_EN to add the history filter (duplicate drop, conflict detect).
module uc_arbiter #(
  parameter int NUM_Q      = 4,
  parameter int LIT_W      = 9,
  parameter int HIST_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  uc_arbiter_if.master bus,
  output logic [1:0]   dbg_state
);

  localparam int PTR_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam logic [PTR_W:0] NQ = (PTR_W + 1)'(NUM_Q);

  if (NUM_Q < 1 || LIT_W < 2 || HIST_DEPTH < 1) begin : g_param_chk
    $error("uc_arbiter: illegal parameter values");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2,
    CONFL = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic [LIT_W-1:0] cand;
  logic [PTR_W-1:0] rr_ptr, rr_nxt, sel;
  logic [PTR_W:0]   sum, sel_inc;
  logic             found, pop_go;
  logic [NUM_Q-1:0] pop_vec;
  logic             dup_hit, neg_hit;

  // First non-empty queue at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (sum >= NQ) sum = sum - NQ;
      if (!found && !bus.q_empty[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_inc = {1'b0, sel} + (PTR_W + 1)'(1);
    rr_nxt  = (sel_inc == NQ) ? '0 : sel_inc[PTR_W-1:0];
  end

  // armed keeps pop low during reset and for the first cycle after release;
  // a flush in IDLE also suppresses the pop so no literal is lost.
  assign pop_go = (state == IDLE) && armed && !bus.flush && found;

  always_comb begin
    pop_vec = '0;
    if (pop_go) pop_vec[sel] = 1'b1;
  end

`ifdef UCA_HIST_FILTER_EN
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [HW:0] HD = (HW + 1)'(HIST_DEPTH);

  logic [LIT_W-1:0]      hist_lit [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [HW-1:0]         wr_ptr, wr_nxt;
  logic [HW:0]           wr_inc;
  logic [LIT_W-1:0]      cand_neg;
  logic                  hs;

  assign cand_neg = -cand;
  assign hs       = (state == SEND) && bus.bcast_ready && !bus.flush;

  always_comb begin
    dup_hit = 1'b0;
    neg_hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_vld[i] && hist_lit[i] == cand)     dup_hit = 1'b1;
      if (hist_vld[i] && hist_lit[i] == cand_neg) neg_hit = 1'b1;
    end
  end

  always_comb begin
    wr_inc = {1'b0, wr_ptr} + (HW + 1)'(1);
    wr_nxt = (wr_inc == HD) ? '0 : wr_inc[HW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld <= '0;
      wr_ptr   <= '0;
    end else if (bus.flush) begin
      hist_vld <= '0;
      wr_ptr   <= '0;
    end else if (hs) begin
      hist_vld[wr_ptr] <= 1'b1;
      wr_ptr           <= wr_nxt;
    end
  end

  // Literal storage needs no reset: entries are qualified by hist_vld.
  always_ff @(posedge clk) begin
    if (hs) hist_lit[wr_ptr] <= cand;
  end

  assign bus.conflict = (state == CONFL);
`else
  assign dup_hit      = 1'b0;
  assign neg_hit      = 1'b0;
  assign bus.conflict = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop_go) state_nxt = CHECK;
      CHECK: begin
        if (cand == '0 || dup_hit) state_nxt = IDLE;
        else if (neg_hit)          state_nxt = CONFL;
        else                       state_nxt = SEND;
      end
      SEND:    if (bus.bcast_ready) state_nxt = IDLE;
      CONFL:   state_nxt = CONFL;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      armed  <= 1'b0;
      cand   <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (bus.flush) begin
        cand   <= '0;
        rr_ptr <= '0;
      end else if (pop_go) begin
        cand   <= bus.q_data[sel];
        rr_ptr <= rr_nxt;
      end
    end
  end

  assign bus.pop         = pop_vec;
  assign bus.bcast_valid = (state == SEND);
  assign bus.bcast_lit   = (state == SEND) ? cand : '0;
  assign dbg_state       = state;

endmodule
